// File: rtl/bus_grant_pkg.sv
// Shared state encoding and default timing constants for the bus grant responder.
package bus_grant_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_GRANTED,
    ST_OWNED,
    ST_TIMEOUT,
    ST_HOLDOFF
  } bg_state_e;

  localparam int BG_GRANT_DLY = 1;
  localparam int BG_ACQ_WIN   = 4;
  localparam int BG_MAX_BUSY  = 64;

endpackage

// File: rtl/bg_cycle_cnt.sv
// Saturating up-counter with synchronous clear, enable and terminal-count compare.
module bg_cycle_cnt
  import bus_grant_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (i_en && (r_cnt != '1))  r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/bus_grant_responder.sv
// Responder end of the req/grant/frame handshake: delays the grant, polices the
// acquisition window and the ownership length, and holds off a stuck requester.
module bus_grant_responder
  import bus_grant_pkg::*;
#(
  parameter int GRANT_DLY = BG_GRANT_DLY,
  parameter int ACQ_WIN   = BG_ACQ_WIN,
  parameter int MAX_BUSY  = BG_MAX_BUSY,
  parameter int CNT_W     = $clog2(MAX_BUSY + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic             i_frame,
  output logic             o_grant,
  output logic             o_aquired,
  output logic             o_time_out,
  output logic [CNT_W-1:0] o_busy_cnt
);

  localparam int DLY_W = 4;
  localparam int ACQ_W = $clog2(ACQ_WIN + 1);
  // IDLE already spends one edge, so DELAY only needs GRANT_DLY-1 edges.
  localparam logic [DLY_W-1:0] DLY_TERM  = DLY_W'((GRANT_DLY >= 2) ? GRANT_DLY - 2 : 0);
  localparam logic [ACQ_W-1:0] ACQ_TERM  = ACQ_W'(ACQ_WIN - 1);
  localparam logic [CNT_W-1:0] BUSY_TERM = CNT_W'(MAX_BUSY - 1);

  bg_state_e r_state, w_next;

  logic             w_dly_tc, w_acq_tc, w_busy_tc;
  logic             w_acq_en, w_busy_en, w_busy_clr;
  logic [DLY_W-1:0] w_dly_cnt;
  logic [ACQ_W-1:0] w_acq_cnt;
  logic             w_grant, w_aquired, w_time_out;
  logic             r_grant, r_aquired, r_time_out;

  assign w_acq_en   = (r_state == ST_GRANTED) && !i_frame;
  assign w_busy_en  = (r_state == ST_OWNED) && i_frame && !w_busy_tc;
  assign w_busy_clr = (r_state != ST_OWNED) && (w_next == ST_OWNED);

  bg_cycle_cnt #(.W(DLY_W)) u_dly_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (r_state != ST_DELAY),
    .i_en   (r_state == ST_DELAY),
    .i_term (DLY_TERM),
    .o_cnt  (w_dly_cnt),
    .o_tc   (w_dly_tc)
  );

  bg_cycle_cnt #(.W(ACQ_W)) u_acq_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (r_state != ST_GRANTED),
    .i_en   (w_acq_en),
    .i_term (ACQ_TERM),
    .o_cnt  (w_acq_cnt),
    .o_tc   (w_acq_tc)
  );

  // Busy count holds outside OWNED so the last ownership length stays visible.
  bg_cycle_cnt #(.W(CNT_W)) u_busy_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_busy_clr),
    .i_en   (w_busy_en),
    .i_term (BUSY_TERM),
    .o_cnt  (o_busy_cnt),
    .o_tc   (w_busy_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_req) w_next = (GRANT_DLY == 1) ? ST_GRANTED : ST_DELAY;
      ST_DELAY: begin
        if (!i_req)        w_next = ST_IDLE;
        else if (w_dly_tc) w_next = ST_GRANTED;
      end
      ST_GRANTED: begin
        if (i_frame)       w_next = ST_OWNED;
        else if (!i_req)   w_next = ST_IDLE;
        else if (w_acq_tc) w_next = ST_TIMEOUT;
      end
      ST_OWNED: begin
        if (!i_frame)       w_next = ST_IDLE;
        else if (w_busy_tc) w_next = ST_TIMEOUT;
      end
      ST_TIMEOUT: w_next = ST_HOLDOFF;
      ST_HOLDOFF: if (!i_req) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_grant    = (r_state == ST_GRANTED) || (r_state == ST_OWNED);
    w_aquired  = (r_state == ST_OWNED);
    w_time_out = (r_state == ST_TIMEOUT);
  end

  // Outputs are registered copies of the current state, one cycle behind it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant    <= 1'b0;
      r_aquired  <= 1'b0;
      r_time_out <= 1'b0;
    end else begin
      r_grant    <= w_grant;
      r_aquired  <= w_aquired;
      r_time_out <= w_time_out;
    end
  end

  assign o_grant    = r_grant;
  assign o_aquired  = r_aquired;
  assign o_time_out = r_time_out;

endmodule

// File: tb/tb_bus_grant_responder.sv
// Scoreboard bench: expected {grant,aquired,time_out} pushed per driven edge, popped after it.
module tb_bus_grant_responder;

  localparam int CNT_W = $clog2(64 + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0, frame = 1'b0, req3 = 1'b0, frame3 = 1'b0;
  logic grant, aq, to, grant3, aq3, to3;
  logic [CNT_W-1:0] busy, busy3;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    bit       sel;
    logic [2:0] exp;
    string    tag;
  } sb_t;
  sb_t q_exp[$];

  always #5 clk = ~clk;

  bus_grant_responder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_frame(frame),
    .o_grant(grant), .o_aquired(aq), .o_time_out(to), .o_busy_cnt(busy)
  );

  bus_grant_responder #(.GRANT_DLY(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req3), .i_frame(frame3),
    .o_grant(grant3), .o_aquired(aq3), .o_time_out(to3), .o_busy_cnt(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one edge's inputs, queue the expected outputs, compare after the edge.
  task automatic step(input bit sel, input logic r, input logic f,
                      input logic [2:0] e, input string tag);
    sb_t s;
    if (sel) begin req3 = r; frame3 = f; end
    else     begin req  = r; frame  = f; end
    q_exp.push_back('{sel, e, tag});
    @(posedge clk); #1;
    s = q_exp.pop_front();
    chk(s.tag, s.sel ? {29'd0, grant3, aq3, to3} : {29'd0, grant, aq, to}, {29'd0, s.exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {29'd0, grant, aq, to}, 32'd0);
    chk("rst_busy", {25'd0, busy}, 32'd0);
    chk("rst_outs3", {29'd0, grant3, aq3, to3}, 32'd0);
    chk("rst_busy3", {25'd0, busy3}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(0, 0, 0, 3'b000, "idle");

    // basic grant and normal release; 9 frame edges counted after OWNED entry
    for (int k = 0; k < 17; k++) begin
      step(0, k <= 11, (k >= 2) && (k <= 11),
           (k == 0) ? 3'b000 : (k <= 2) ? 3'b100 : (k <= 12) ? 3'b110 : 3'b000, "basic");
      if (k == 16) chk("basic_busy", {25'd0, busy}, 32'd9);
    end

    // busy timeout, holdoff while req stays high, re-grant after req drops
    for (int k = 0; k < 86; k++) begin
      step(0, (k <= 75) || (k == 77), (k >= 2) && (k <= 71),
           (k == 0) ? 3'b000 : (k <= 2) ? 3'b100 : (k <= 66) ? 3'b110 :
           (k == 67) ? 3'b001 : (k == 78) ? 3'b100 : 3'b000, "busy_to");
      if (k == 64) chk("busy_62", {25'd0, busy}, 32'd62);
      if (k == 65) chk("busy_63", {25'd0, busy}, 32'd63);
      if (k == 67) chk("busy_hold_to", {25'd0, busy}, 32'd63);
      if (k == 85) chk("busy_hold_idle", {25'd0, busy}, 32'd63);
    end

    // acquisition timeout: grant for exactly 4 cycles, then pulse, then holdoff
    for (int k = 0; k < 12; k++)
      step(0, k <= 7, 0,
           (k == 0) ? 3'b000 : (k <= 4) ? 3'b100 : (k == 5) ? 3'b001 : 3'b000, "acq_to");

    // aborted request with GRANT_DLY=3, then a full request proving IDLE
    for (int k = 0; k < 8; k++) step(1, k <= 1, 0, 3'b000, "abort");
    for (int k = 0; k < 8; k++)
      step(1, k <= 4, 0, ((k >= 3) && (k <= 5)) ? 3'b100 : 3'b000, "dly3");

    // frame wins over req drop; release with req high re-arbitrates
    for (int k = 0; k < 11; k++)
      step(0, (k != 1) && (k <= 6), (k >= 1) && (k <= 4),
           (k == 0) ? 3'b000 : (k == 1) ? 3'b100 : (k <= 5) ? 3'b110 :
           (k == 7) ? 3'b100 : 3'b000, "simul");

    // reset mid-ownership
    for (int k = 0; k < 33; k++) begin
      step(0, 1, k >= 2, (k == 0) ? 3'b000 : (k <= 2) ? 3'b100 : 3'b110, "pre_rst");
      if (k == 32) chk("busy_30", {25'd0, busy}, 32'd30);
    end
    #2;
    rst_n = 1'b0;
    req = 1'b0;
    frame = 1'b0;
    #1;
    chk("async_outs", {29'd0, grant, aq, to}, 32'd0);
    chk("async_busy", {25'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", {29'd0, grant, aq, to}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++)
      step(0, k <= 2, 0, ((k >= 1) && (k <= 3)) ? 3'b100 : 3'b000, "post_rst");

    chk("sb_empty", q_exp.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
